// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// State encodings and one-hot grant values used by the arbiter core.
`timescale 1ns/1ps
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Round-robin history: which master was granted most recently.
    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    function automatic logic [1:0] grant_of(input arb_state_e s);
        logic [1:0] g;
        g = GRANT_NONE;
        case (s)
            ST_GNT0: g = GRANT_M0;
            ST_GNT1: g = GRANT_M1;
            default: g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts consecutive unacknowledged strobe cycles and flags
// the cycle in which the count would reach TIMEOUT. TIMEOUT = 0 disables it.
`timescale 1ns/1ps
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expire in the TIMEOUT-th waiting cycle itself, so err lines up with it.
    assign expire = ENABLED && count_en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (count_en && ENABLED) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter with a stall watchdog.
// Valid/ready: a granted master's stb_i is held until ack_o (done) or err_o (aborted).
`timescale 1ns/1ps
module wishbone_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_int_o,

    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_int_o,

    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_int_i,

    output logic [1:0]  grant_o,
    output logic [1:0]  dbg_state_o
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       wd_clear, wd_count_en, wd_expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_M1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Owner keeps the bus while its cyc_i is high; hand-over skips IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = (last_grant_q == LAST_M1) ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    state_d = ST_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (wd_expire) begin
                    state_d = ST_IDLE;
                end else if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (wd_expire) begin
                    state_d = ST_IDLE;
                end else if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        last_grant_d = last_grant_q;
        if (state_d == ST_GNT0) begin
            last_grant_d = LAST_M0;
        end else if (state_d == ST_GNT1) begin
            last_grant_d = LAST_M1;
        end
    end

    always_comb begin
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            ST_GNT0: begin
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = wd_expire;
            end
            ST_GNT1: begin
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = wd_expire;
            end
            default: ;
        endcase
    end

    assign m0_int_o    = s_int_i;
    assign m1_int_o    = s_int_i;
    assign grant_o     = grant_of(state_q);
    assign dbg_state_o = state_q;

    // An ack in the expiry cycle masks the count enable, so ack wins.
    assign wd_count_en = s_stb_o & ~s_ack_i;
    assign wd_clear    = (state_d != state_q) || (state_q == ST_IDLE) || s_ack_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expire   (wd_expire)
    );

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed scenarios for arbitration, hand-over, timeout and reset, then a
// randomized two-master run checked against an expected-response scoreboard.
`timescale 1ns/1ps
module tb_wishbone_arbiter;

    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        cyc_r, stb_r, we_r;
    logic [1:0][31:0]  adr_r, wdat_r;
    logic [1:0][31:0]  rdat_w;
    logic [1:0]        ack_w, err_w, int_w;
    logic              s_we, s_cyc, s_stb, s_ack, s_int;
    logic [31:0]       s_adr, s_wdat, s_rdat;
    logic [1:0]        grant, dbg_state;

    logic              slv_auto, slv_ack, dir_ack;
    logic [31:0]       slv_dat, dir_dat;
    logic              mon_en;

    int                n_chk, n_pass;
    logic [32:0]       exp_q0[$];
    logic [32:0]       exp_q1[$];

    assign s_ack  = slv_auto ? slv_ack : dir_ack;
    assign s_rdat = slv_auto ? slv_dat : dir_dat;

    always #5 clk = ~clk;

    wishbone_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_we_i     (we_r[0]),
        .m0_cyc_i    (cyc_r[0]),
        .m0_stb_i    (stb_r[0]),
        .m0_adr_i    (adr_r[0]),
        .m0_dat_i    (wdat_r[0]),
        .m0_dat_o    (rdat_w[0]),
        .m0_ack_o    (ack_w[0]),
        .m0_err_o    (err_w[0]),
        .m0_int_o    (int_w[0]),
        .m1_we_i     (we_r[1]),
        .m1_cyc_i    (cyc_r[1]),
        .m1_stb_i    (stb_r[1]),
        .m1_adr_i    (adr_r[1]),
        .m1_dat_i    (wdat_r[1]),
        .m1_dat_o    (rdat_w[1]),
        .m1_ack_o    (ack_w[1]),
        .m1_err_o    (err_w[1]),
        .m1_int_o    (int_w[1]),
        .s_we_o      (s_we),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_adr_o     (s_adr),
        .s_dat_o     (s_wdat),
        .s_dat_i     (s_rdat),
        .s_ack_i     (s_ack),
        .s_int_i     (s_int),
        .grant_o     (grant),
        .dbg_state_o (dbg_state)
    );

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_all();
        cyc_r = '0; stb_r = '0; we_r = '0;
        adr_r = '0; wdat_r = '0;
        dir_ack = 1'b0; dir_dat = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic req(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
        cyc_r[m] = 1'b1; stb_r[m] = 1'b1; we_r[m] = we; adr_r[m] = a; wdat_r[m] = d;
    endtask

    task automatic drop(input int m);
        cyc_r[m] = 1'b0; stb_r[m] = 1'b0;
    endtask

    // Bounded wait for the master's own ack/err, sampled at the falling edge.
    task automatic wait_resp(input int m, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (ack_w[m] || err_w[m]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("resp_bound", 64'(ack_w[m] | err_w[m]), 64'd1);
    endtask

    task automatic run_master(input int m);
        logic [31:0] a;
        logic        ok;
        int          gap, beats;
        for (int t = 0; t < 25; t++) begin
            gap   = $urandom_range(0, 3);
            beats = $urandom_range(1, 3);
            repeat (gap) step();
            for (int b = 0; b < beats; b++) begin
                a = $urandom;
                req(m, 1'($urandom_range(0, 1)), a, $urandom);
                if (m == 0) exp_q0.push_back({1'b0, hash(a)});
                else        exp_q1.push_back({1'b0, hash(a)});
                wait_resp(m, ok);
                step();
                if (!ok) break;
            end
            drop(m);
            step();
        end
    endtask

    // Slave: random ack latency 0..2 cycles, read data derived from address.
    initial begin : slave
        int wc, lat;
        wc = 0; lat = $urandom_range(0, 2);
        slv_ack = 1'b0; slv_dat = '0; s_int = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            slv_ack = 1'b0;
            slv_dat = $urandom;
            s_int   = 1'($urandom_range(0, 1));
            if (slv_auto && s_cyc && s_stb) begin
                if (wc >= lat) begin
                    slv_ack = 1'b1;
                    slv_dat = hash(s_adr);
                    wc      = 0;
                    lat     = $urandom_range(0, 2);
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    initial begin : monitor
        logic [1:0]  pg, pc;
        logic [32:0] e;
        pg = '0; pc = '0;
        forever begin
            @(negedge clk);
            chk("int_fanout", 64'(int_w), 64'({s_int, s_int}));
            if (mon_en) begin
                if (ack_w[0] || err_w[0]) begin
                    if (exp_q0.size() == 0) chk("m0_unexpected_resp", 64'(ack_w[0] | err_w[0]), 64'd0);
                    else begin
                        e = exp_q0.pop_front();
                        chk("m0_resp", 64'({err_w[0], ack_w[0] ? rdat_w[0] : 32'h0}), 64'(e));
                        if (ack_w[0]) chk("m0_wr_route", 64'({s_we, s_wdat}), 64'({we_r[0], wdat_r[0]}));
                    end
                end
                if (ack_w[1] || err_w[1]) begin
                    if (exp_q1.size() == 0) chk("m1_unexpected_resp", 64'(ack_w[1] | err_w[1]), 64'd0);
                    else begin
                        e = exp_q1.pop_front();
                        chk("m1_resp", 64'({err_w[1], ack_w[1] ? rdat_w[1] : 32'h0}), 64'(e));
                        if (ack_w[1]) chk("m1_wr_route", 64'({s_we, s_wdat}), 64'({we_r[1], wdat_r[1]}));
                    end
                end
                chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
                if (pg == 2'b01 && pc[0]) chk("no_preempt_m0", 64'(grant), 64'd1);
                if (pg == 2'b10 && pc[1]) chk("no_preempt_m1", 64'(grant), 64'd2);
                for (int m = 0; m < 2; m++)
                    if (!cyc_r[m]) chk("ack_without_cyc", 64'(ack_w[m] | err_w[m]), 64'd0);
            end
            pg = grant;
            pc = cyc_r;
        end
    end

    initial begin : main
        n_chk = 0; n_pass = 0;
        slv_auto = 1'b0; mon_en = 1'b0;
        idle_all();
        #3;
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_s_cyc", 64'({s_cyc, s_stb, s_we}), 64'd0);
        chk("reset_resp", 64'({ack_w, err_w}), 64'd0);
        chk("reset_dbg_state", 64'(dbg_state), 64'd0);

        // Single write by m0, ack in the second granted cycle.
        do_reset();
        req(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5);
        sample();
        chk("wr_cyc_latency0", 64'(s_cyc), 64'd0);
        chk("wr_grant_N", 64'(grant), 64'd0);
        step(); sample();
        chk("wr_cyc_latency1", 64'(s_cyc), 64'd1);
        chk("wr_grant_N1", 64'(grant), 64'd1);
        chk("wr_bus", 64'({s_we, s_stb, s_adr}), 64'({1'b1, 1'b1, 32'h10}));
        chk("wr_dat", 64'(s_wdat), 64'h0000_0000_A5A5_A5A5);
        step(); dir_ack = 1'b1; sample();
        chk("wr_ack", 64'(ack_w), 64'd1);
        step(); dir_ack = 1'b0; drop(0); sample();
        chk("wr_ack_pulse", 64'(ack_w), 64'd0);
        step(); sample();
        chk("wr_grant_idle", 64'(grant), 64'd0);

        // Contention after reset, then direct hand-over to m1.
        do_reset();
        req(0, 1'b0, 32'h100, 32'h0);
        req(1, 1'b0, 32'h200, 32'h0);
        step(); dir_ack = 1'b1; sample();
        chk("rr_first_m0", 64'(grant), 64'd1);
        chk("rr_first_adr", 64'(s_adr), 64'h100);
        step(); dir_ack = 1'b0; drop(0); sample();
        chk("rr_hold_release", 64'(grant), 64'd1);
        step(); dir_ack = 1'b1; sample();
        chk("rr_handover_m1", 64'(grant), 64'd2);
        chk("rr_m1_ack", 64'(ack_w), 64'd2);
        step(); dir_ack = 1'b0; drop(1);
        step(); sample();
        chk("rr_idle", 64'(grant), 64'd0);

        // m1 4-beat burst while m0 waits.
        do_reset();
        req(1, 1'b1, 32'h300, 32'h1111);
        for (int i = 0; i < 4; i++) begin
            step();
            req(0, 1'b0, 32'h700, 32'h0);
            adr_r[1] = 32'h300 + 32'(4 * i);
            dir_ack = 1'b1;
            sample();
            chk("burst_grant_m1", 64'(grant), 64'd2);
            chk("burst_ack_m1", 64'(ack_w), 64'd2);
            chk("burst_adr", 64'(s_adr), 64'(32'h300 + 32'(4 * i)));
        end
        step(); dir_ack = 1'b0; drop(1); sample();
        chk("burst_release", 64'(grant), 64'd2);
        step(); dir_ack = 1'b1; sample();
        chk("burst_next_m0", 64'(grant), 64'd1);
        chk("burst_m0_ack", 64'(ack_w), 64'd1);
        step(); dir_ack = 1'b0; drop(0);
        step();

        // Ack in the fourth waiting cycle beats the timeout.
        req(0, 1'b0, 32'h440, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            dir_ack = (i == 4);
            sample();
            chk("ack_vs_timeout_err", 64'(err_w), 64'd0);
        end
        chk("ack_vs_timeout_ack", 64'(ack_w), 64'd1);
        step(); dir_ack = 1'b0; drop(0);
        step();

        // m1 timeout: err exactly in 4th waiting cycle, then IDLE.
        do_reset();
        req(1, 1'b0, 32'h400, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step(); sample();
            chk("to_err", 64'(err_w), (i == 4) ? 64'd2 : 64'd0);
            chk("to_grant", 64'(grant), 64'd2);
        end
        step(); drop(1); sample();
        chk("to_idle", 64'(grant), 64'd0);
        chk("to_err_once", 64'(err_w), 64'd0);
        step(); req(1, 1'b0, 32'h404, 32'h0);
        step(); dir_ack = 1'b1; sample();
        chk("to_rearb", 64'({grant, ack_w, err_w}), 64'({2'b10, 2'b10, 2'b00}));
        step(); dir_ack = 1'b0; drop(1);
        step();

        // Read data reaches only the owner.
        req(1, 1'b0, 32'h500, 32'h0);
        step(); dir_ack = 1'b1; dir_dat = 32'h1234_5678; sample();
        chk("rd_owner_dat", 64'(rdat_w[1]), 64'h1234_5678);
        chk("rd_other_dat", 64'(rdat_w[0]), 64'd0);
        chk("rd_ack", 64'(ack_w), 64'd2);
        step(); dir_ack = 1'b0; dir_dat = '0; drop(1);
        step();

        // Asynchronous reset mid-wait, then contention grants m0 again.
        do_reset();
        req(0, 1'b1, 32'h600, 32'hDEAD_BEEF);
        step(); sample();
        chk("arst_pre_grant", 64'(grant), 64'd1);
        #2;
        rst = 1'b0;
        dir_ack = 1'b1;
        #1;
        chk("arst_bus_drop", 64'({s_cyc, s_stb}), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_no_resp", 64'({ack_w, err_w}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dir_ack = 1'b0;
        req(1, 1'b0, 32'h604, 32'h0);
        sample();
        chk("arst_idle_after", 64'(grant), 64'd0);
        step(); sample();
        chk("arst_contention_m0", 64'(grant), 64'd1);
        idle_all();
        step();

        // Randomized two-master traffic.
        do_reset();
        slv_auto = 1'b1;
        mon_en   = 1'b1;
        fork
            run_master(0);
            run_master(1);
        join
        repeat (5) step();
        mon_en = 1'b0;
        chk("q0_drained", 64'(exp_q0.size()), 64'd0);
        chk("q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : global_bound
        #400000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles a granted strobe may wait for s_ack_i; 0 disables the watchdog.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 m0_we_i, m0_cyc_i, m0_stb_i  input  1 each  master 0 write enable, cycle, strobe.
REQ-005 m0_adr_i, m0_dat_i  input  32 each  master 0 address and write data.
REQ-006 m0_dat_o  output  32  master 0 read data; m0_ack_o, m0_err_o, m0_int_o  output  1 each  acknowledge, timeout error, interrupt.
REQ-007 m1_* ports SHALL be identical to m0_* for master 1.
REQ-008 s_we_o, s_cyc_o, s_stb_o  output  1 each; s_adr_o, s_dat_o  output  32 each: shared bus toward the interconnect.
REQ-009 s_dat_i  input  32; s_ack_i, s_int_i  input  1 each: shared bus return.
REQ-010 grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.

Function
REQ-011 FSM states: IDLE, GNT0, GNT1; state registered, output mux combinational from state.
REQ-012 IDLE: only m0_cyc_i high -> GNT0; only m1_cyc_i high -> GNT1; both -> master not granted last (round-robin via last_grant register); neither -> stay IDLE.
REQ-013 Grant latency: cyc asserted in cycle N from IDLE -> s_cyc_o follows that master in cycle N+1.
REQ-014 In GNTx, s_we/cyc/stb/adr/dat_o SHALL equal master x inputs; in IDLE all s_* outputs are 0.
REQ-015 In GNTx, mx_dat_o = s_dat_i, mx_ack_o = s_ack_i; non-owner dat_o = 0, ack_o = 0, err_o = 0.
REQ-016 Ownership SHALL hold while owner's cyc_i stays high, regardless of other requests (no preemption, supports block transfers).
REQ-017 Owner drops cyc_i: if the other master's cyc_i is high at that edge, move directly to its GNT state; otherwise IDLE.
REQ-018 last_grant SHALL update on every entry to GNT0/GNT1.
REQ-019 Watchdog: counter (width $clog2(TIMEOUT+1)) increments each cycle s_stb_o=1 and s_ack_i=0, clears on ack, on any state change, or in IDLE.
REQ-020 Counter reaching TIMEOUT: owner's err_o high for exactly one cycle, counter clears, next state IDLE (transaction aborted); master re-arbitrates normally afterwards.
REQ-021 s_ack_i and timeout in the same cycle: ack wins, no err.
REQ-022 m0_int_o = m1_int_o = s_int_i at all times, independent of grant.

Reset
REQ-023 rst low SHALL asynchronously force state IDLE, counter 0, last_grant = m1 (so m0 wins first contention); all outputs per IDLE (0).
REQ-024 rst asserted mid-transfer SHALL drop s_cyc_o/s_stb_o immediately with no ack or err to either master.

Structure
REQ-025 State encodings and grant one-hot constants SHALL live in shared package wb_arb_pkg.
REQ-026 Watchdog SHALL be sub-module wb_arb_watchdog (inputs clk, rst, clear, count_en; output expire).
REQ-027 Estimated 150-250 lines RTL, no memories.

Verification
REQ-028 m0 single write adr 0x00000010 dat 0xA5A5A5A5, slave acks in 2 cycles -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o pulses, grant_o 01 then 00.
REQ-029 m0 and m1 request same cycle after reset -> m0 granted first; m0 drops cyc with m1 still high -> grant_o 01 -> 10 with no IDLE cycle.
REQ-030 m1 issues 4-beat burst holding cyc while m0 requests -> m1 keeps grant all 4 acks; m0 granted next cycle after m1 releases.
REQ-031 TIMEOUT=4, m1 strobes, slave never acks -> m1_err_o high exactly once in 4th waiting cycle, state IDLE next cycle, m0 sees no err.
REQ-032 Read from slave returning 0x12345678 while other master idle -> only owner's dat_o shows 0x12345678, non-owner dat_o 0.
REQ-033 rst pulsed low mid-wait -> s_cyc_o, grant_o drop to 0 asynchronously; after release, contention grants m0.
